pl_debug_ctrl: RTL and testbench
================================

# pl_debug_ctrl

Run/step/breakpoint controller for the pipelined CPU core. It gates the core through a clock-enable, halts it on a PC breakpoint, and supports single-stepping. While the core is halted, it sequences the core's debug register-read port (`m_rf_addr` / `rf_data`) to stream out a block of debug registers. It sits between the board-level debug unit (buttons/UART) and the CPU core.

## Interface
- No parameters. Address width is fixed at 8 bits and data width at 32 bits.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: one-cycle pulse. Enter or resume free-running.
- `halt` in 1: one-cycle pulse. Stop the core.
- `step` in 1: one-cycle pulse. Advance the core exactly one enabled cycle.
- `brk_en` in 1: breakpoint enable (level).
- `brk_addr` in 32: breakpoint PC.
- `pc` in 32: core fetch PC (`pc_out`).
- `cpu_en` out 1: core clock-enable.
- `scan_req` in 1: one-cycle pulse. Start a debug-register scan.
- `scan_start` in 8: first debug address.
- `scan_len` in 8: word count; 0 means 256.
- `m_rf_addr` out 8: debug address driven to the core.
- `rf_data` in 32: core debug read data (combinational from `m_rf_addr`).
- `scan_data` out 32: captured word.
- `scan_valid` out 1: one-cycle strobe with `scan_data`.
- `scan_done` out 1: one-cycle strobe after the last word.
- `status` out 2: 0 HALT, 1 RUN, 2 BRK, 3 SCAN.
- `cycle_cnt` out 32: enabled-cycle counter (see Configuration).

## Operation
- **States:** HALT, RUN, STEP, BRK, SCAN. Reset state is HALT.
- **`cpu_en`:**
  - Asserted only in STEP, or in RUN with `bp_hit`=0.
  - `bp_hit` = `brk_en` && `pc`==`brk_addr` && !`skip`. It is combinational, so the core never executes the matching cycle.
- **HALT:**
  - `run` → RUN.
  - `step` → STEP.
  - `scan_req` → SCAN.
  - Priority: `run` > `step` > `scan_req`.
- **RUN:**
  - `bp_hit` → BRK in the same cycle (with `cpu_en`=0).
  - Otherwise `halt` → HALT. `halt` takes effect at the next edge, and `cpu_en`=1 in the `halt` cycle.
  - `step` and `scan_req` are ignored in RUN.
- **STEP:**
  - Exactly one cycle with `cpu_en`=1, then HALT.
  - Breakpoints are not checked in STEP.
- **BRK:**
  - Same transitions as HALT.
  - Leaving BRK via `run` or `step` sets `skip`=1. `skip` clears after the first cycle with `cpu_en`=1, so resuming at the breakpoint PC executes it once.
- **SCAN:**
  - Index i runs 0..N-1, where N = `scan_len` (0 → 256).
  - `m_rf_addr` = `scan_start` + i, modulo 256 (wraps 255 → 0).
  - Each cycle, `rf_data` is registered into `scan_data`, and `scan_valid` pulses the following cycle.
  - After word N-1 is captured: `scan_done` pulses together with the final `scan_valid`, and the state returns to the state SCAN was entered from (HALT or BRK).
  - `run`, `step` and `halt` are ignored during SCAN.
  - `scan_start` and `scan_len` are latched on `scan_req`.
- **`m_rf_addr` outside SCAN:** holds its last value. Reset value is 0.
- **`halt` in HALT or BRK:** no effect.

## Timing
- **Reset values:**
  - state HALT; `cpu_en`=0; `m_rf_addr`=0.
  - `scan_data`=0; `scan_valid`=0; `scan_done`=0.
  - `status`=0; `cycle_cnt`=0; `skip`=0.
- **Asynchronous reset mid-scan or mid-run:** everything returns to reset values immediately. No partial `scan_done` is issued.
- **Latencies:**
  - `run` or `step` pulse → `cpu_en` high on the next cycle (1-cycle latency).
  - `scan_req` → first `m_rf_addr` next cycle. First `scan_valid` 2 cycles after `scan_req`. `scan_done` N+1 cycles after `scan_req`.
  - Scan throughput is one word per cycle.
- **`status`:** registered; reflects the current state.

## Configuration
- **Macro `PL_DBG_CYCLE_CNT_EN`.**
- **Defined:**
  - `cycle_cnt` increments on every cycle with `cpu_en`=1, wrapping modulo 2^32.
  - It is cleared only by `rst`.
- **Undefined:** `cycle_cnt` is tied to 0 and no counter register is built.

## Test plan
- **Step:** reset, then `step` pulse → `cpu_en` high exactly 1 cycle, `status` returns to 0. `cycle_cnt`=1 with the macro defined.
- **Breakpoint:** `brk_en`=1, `brk_addr`=0x0000_000C, `run`, `pc` advancing 0,4,8,C → `cpu_en` low in the cycle `pc`=0x0C, `status`=2.
- **Resume:** from BRK at 0x0C, `run` → core executes 0x0C (`cpu_en`=1), continues to 0x10. A later return to 0x0C halts again.
- **Scan:** in HALT, `scan_req` with start=0x1E, len=4 → `m_rf_addr` 0x1E,0x1F,0x20,0x21; 4 `scan_valid` strobes with matching `rf_data`; `scan_done` on the 4th strobe; `status` back to 0.
- **Wrap and len=0:** start=0xFF, len=0 → 256 words, addresses 0xFF,0x00..0xFE; `scan_done` 257 cycles after `scan_req`.
- **Reset mid-scan and ignored inputs:** assert `rst` after 2 words → all outputs return to reset values, no `scan_done`. Separately, `scan_req` while RUN is ignored and `status` stays 1.

Source files
------------

// File: rtl/pl_debug_ctrl_if.sv
// ---------------------------------------------------------------------------
// pl_debug_ctrl_if
//
// Purpose:
//   Bundles the debug-controller signals that run between the board debug
//   unit, the CPU core and pl_debug_ctrl.
//
// Modports:
//   master - used by pl_debug_ctrl.
//            Inputs:  run/halt/step/scan_req pulses, breakpoint setup,
//                     core PC, scan window and core debug read data.
//            Outputs: core clock-enable, debug address, scan results,
//                     status and enabled-cycle counter.
//   slave  - the mirror view, for the debug unit / core side.
//
// Signals:
//   run, halt, step    one-cycle control pulses
//   brk_en, brk_addr   breakpoint enable (level) and breakpoint PC
//   pc                 core fetch PC
//   cpu_en             core clock-enable
//   scan_req           one-cycle pulse starting a debug-register scan
//   scan_start         first debug address of the scan
//   scan_len           word count (0 means 256)
//   m_rf_addr          debug register address driven to the core
//   rf_data            core debug read data, combinational from m_rf_addr
//   scan_data          captured word
//   scan_valid         one-cycle strobe qualifying scan_data
//   scan_done          one-cycle strobe with the last scan_valid
//   status             0 HALT, 1 RUN, 2 BRK, 3 SCAN
//   cycle_cnt          enabled-cycle counter
// ---------------------------------------------------------------------------
interface pl_debug_ctrl_if;
  logic        run;
  logic        halt;
  logic        step;
  logic        brk_en;
  logic [31:0] brk_addr;
  logic [31:0] pc;
  logic        cpu_en;
  logic        scan_req;
  logic [7:0]  scan_start;
  logic [7:0]  scan_len;
  logic [7:0]  m_rf_addr;
  logic [31:0] rf_data;
  logic [31:0] scan_data;
  logic        scan_valid;
  logic        scan_done;
  logic [1:0]  status;
  logic [31:0] cycle_cnt;

  modport master (
    input  run,
    input  halt,
    input  step,
    input  brk_en,
    input  brk_addr,
    input  pc,
    input  scan_req,
    input  scan_start,
    input  scan_len,
    input  rf_data,
    output cpu_en,
    output m_rf_addr,
    output scan_data,
    output scan_valid,
    output scan_done,
    output status,
    output cycle_cnt
  );

  modport slave (
    output run,
    output halt,
    output step,
    output brk_en,
    output brk_addr,
    output pc,
    output scan_req,
    output scan_start,
    output scan_len,
    output rf_data,
    input  cpu_en,
    input  m_rf_addr,
    input  scan_data,
    input  scan_valid,
    input  scan_done,
    input  status,
    input  cycle_cnt
  );
endinterface

// File: rtl/pl_debug_ctrl.sv
// ---------------------------------------------------------------------------
// pl_debug_ctrl
//
// Purpose:
//   Run/step/breakpoint controller for the pipelined CPU core. Gates the core
//   through cpu_en, stops it on a PC breakpoint, single-steps it, and while
//   the core is stopped streams a block of debug registers out through the
//   core's debug read port.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   dbg  - pl_debug_ctrl_if.master (control pulses, breakpoint, PC, scan
//          window, debug read port, status and cycle counter)
//
// Configuration:
//   PL_DBG_CYCLE_CNT_EN - when defined, dbg.cycle_cnt counts every cycle
//   with cpu_en=1 (wrapping at 2^32, cleared only by rst). When undefined,
//   dbg.cycle_cnt is tied to 0 and no counter register exists.
// ---------------------------------------------------------------------------
module pl_debug_ctrl (
  input  logic            clk,
  input  logic            rst,
  pl_debug_ctrl_if.master dbg
);

  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_BRK  = 3'd3,
    ST_SCAN = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_HALT = 2'd0;
  localparam logic [1:0] STATUS_RUN  = 2'd1;
  localparam logic [1:0] STATUS_BRK  = 2'd2;
  localparam logic [1:0] STATUS_SCAN = 2'd3;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  status_q;
  logic [1:0]  status_nxt;

  logic        skip_q;
  logic        ret_brk_q;
  logic [8:0]  words_left_q;
  logic [7:0]  rf_addr_q;
  logic [31:0] scan_data_q;
  logic        scan_valid_q;
  logic        scan_done_q;

  logic        bp_hit;
  logic        cpu_en_c;
  logic        scan_go;
  logic        last_word;
  logic        leave_brk;

  // The breakpoint compare is combinational so the matching cycle is
  // suppressed before the core ever executes it. skip_q masks it for the
  // first enabled cycle after resuming from BRK.
  assign bp_hit    = dbg.brk_en && (dbg.pc == dbg.brk_addr) && !skip_q;
  assign last_word = (words_left_q == 9'd1);
  assign leave_brk = (state == ST_BRK) && (dbg.run || dbg.step);

  always_comb begin
    state_nxt = state;
    cpu_en_c  = 1'b0;
    scan_go   = 1'b0;
    case (state)
      ST_HALT, ST_BRK: begin
        if (dbg.run) begin
          state_nxt = ST_RUN;
        end else if (dbg.step) begin
          state_nxt = ST_STEP;
        end else if (dbg.scan_req) begin
          state_nxt = ST_SCAN;
          scan_go   = 1'b1;
        end
      end
      ST_RUN: begin
        // Breakpoint wins over halt; the halt cycle itself still executes.
        if (bp_hit) begin
          state_nxt = ST_BRK;
        end else begin
          cpu_en_c = 1'b1;
          if (dbg.halt) begin
            state_nxt = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        cpu_en_c  = 1'b1;
        state_nxt = ST_HALT;
      end
      ST_SCAN: begin
        if (last_word) begin
          state_nxt = ret_brk_q ? ST_BRK : ST_HALT;
        end
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  // STEP is reported as RUN: the core is executing during that cycle.
  always_comb begin
    status_nxt = STATUS_HALT;
    case (state_nxt)
      ST_HALT: status_nxt = STATUS_HALT;
      ST_RUN:  status_nxt = STATUS_RUN;
      ST_STEP: status_nxt = STATUS_RUN;
      ST_BRK:  status_nxt = STATUS_BRK;
      ST_SCAN: status_nxt = STATUS_SCAN;
      default: status_nxt = STATUS_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HALT;
      status_q <= STATUS_HALT;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
    end
  end

  // skip is armed when leaving BRK (cpu_en is 0 in BRK, so no conflict with
  // the clear) and dropped after the first executed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q <= 1'b0;
    end else if (leave_brk) begin
      skip_q <= 1'b1;
    end else if (cpu_en_c) begin
      skip_q <= 1'b0;
    end
  end

  // Remembers whether the scan was launched from BRK so the breakpoint
  // context survives a register dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_brk_q <= 1'b0;
    end else if (scan_go) begin
      ret_brk_q <= (state == ST_BRK);
    end
  end

  // Scan engine: the window is latched on acceptance, one word is captured
  // per SCAN cycle, and the address holds at the last word afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_addr_q    <= 8'd0;
      words_left_q <= 9'd0;
      scan_data_q  <= 32'd0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      scan_valid_q <= (state == ST_SCAN);
      scan_done_q  <= (state == ST_SCAN) && last_word;
      if (scan_go) begin
        rf_addr_q    <= dbg.scan_start;
        words_left_q <= (dbg.scan_len == 8'd0) ? 9'd256 : {1'b0, dbg.scan_len};
      end else if (state == ST_SCAN) begin
        scan_data_q <= dbg.rf_data;
        if (last_word) begin
          words_left_q <= 9'd0;
        end else begin
          rf_addr_q    <= rf_addr_q + 8'd1;
          words_left_q <= words_left_q - 9'd1;
        end
      end
    end
  end

`ifdef PL_DBG_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
    end else if (cpu_en_c) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign dbg.cycle_cnt = cycle_cnt_q;
`else
  assign dbg.cycle_cnt = 32'd0;
`endif

  assign dbg.cpu_en     = cpu_en_c;
  assign dbg.m_rf_addr  = rf_addr_q;
  assign dbg.scan_data  = scan_data_q;
  assign dbg.scan_valid = scan_valid_q;
  assign dbg.scan_done  = scan_done_q;
  assign dbg.status     = status_q;

endmodule

// File: tb/tb_pl_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pl_debug_ctrl
//
// Purpose:
//   Self-checking bench for pl_debug_ctrl. A simple core model advances the
//   PC on every enabled cycle and a random register file answers debug reads.
//   A behavioural model checks every output on every falling edge; directed
//   sequences pin the model with hand-computed literals; a random phase
//   exercises priorities, breakpoints, scans from HALT/BRK and async resets.
//   Every rst assertion is held across at least one falling edge so the
//   checker sees it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pl_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] core_pc;
  logic [31:0] wrap_pc;
  logic [31:0] rf_mem [256];

  int checks_total  = 0;
  int checks_passed = 0;

  pl_debug_ctrl_if dbg_if ();

  pl_debug_ctrl dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg_if)
  );

  always #5 clk = ~clk;

  // Core stand-in: PC advances by 4 per executed cycle and loops back to 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_pc <= 32'd0;
    end else if (dbg_if.cpu_en) begin
      core_pc <= (core_pc >= wrap_pc) ? 32'd0 : core_pc + 32'd4;
    end
  end

  assign dbg_if.pc      = core_pc;
  assign dbg_if.rf_data = rf_mem[dbg_if.m_rf_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives the given pulses for exactly one cycle. Call at posedge+1.
  task automatic applyStimulus(input bit p_run, input bit p_halt, input bit p_step, input bit p_scan);
    dbg_if.run      = p_run;
    dbg_if.halt     = p_halt;
    dbg_if.step     = p_step;
    dbg_if.scan_req = p_scan;
    @(posedge clk); #1;
    dbg_if.run      = 1'b0;
    dbg_if.halt     = 1'b0;
    dbg_if.step     = 1'b0;
    dbg_if.scan_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: the controller is described by "is the core running,
  // stepping or parked at a breakpoint" plus a queue of pending scan
  // addresses. Outputs are checked first, then the model advances using the
  // inputs that the next rising edge will sample.
  // -------------------------------------------------------------------------
  bit          m_running, m_stepping, m_parked_brk, m_skip;
  logic [7:0]  m_pending [$];
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  bit          m_valid, m_done;
  logic [31:0] m_cnt;

  initial begin
    bit          in_scan, bp, exp_en;
    logic [1:0]  exp_status;
    logic [7:0]  exp_addr;
    logic [31:0] exp_cnt;
    int          n;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_running = 0; m_stepping = 0; m_parked_brk = 0; m_skip = 0;
        m_pending.delete();
        m_addr = 8'd0; m_data = 32'd0; m_valid = 0; m_done = 0; m_cnt = 32'd0;
      end
      in_scan    = (m_pending.size() != 0);
      bp         = dbg_if.brk_en && (dbg_if.pc == dbg_if.brk_addr) && !m_skip;
      exp_en     = !rst && (m_stepping || (m_running && !bp));
      exp_status = in_scan ? 2'd3 : (m_running || m_stepping) ? 2'd1 : m_parked_brk ? 2'd2 : 2'd0;
      exp_addr   = in_scan ? m_pending[0] : m_addr;
`ifdef PL_DBG_CYCLE_CNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 32'd0;
`endif
      checkOutput("m_cpu_en", {31'd0, dbg_if.cpu_en}, {31'd0, exp_en});
      checkOutput("m_status", {30'd0, dbg_if.status}, {30'd0, exp_status});
      checkOutput("m_rf_addr", {24'd0, dbg_if.m_rf_addr}, {24'd0, exp_addr});
      checkOutput("m_scan_valid", {31'd0, dbg_if.scan_valid}, {31'd0, m_valid});
      checkOutput("m_scan_done", {31'd0, dbg_if.scan_done}, {31'd0, m_done});
      checkOutput("m_scan_data", dbg_if.scan_data, m_data);
      checkOutput("m_cycle_cnt", dbg_if.cycle_cnt, exp_cnt);
      if (!rst) begin
        m_valid = in_scan;
        m_done  = in_scan && (m_pending.size() == 1);
        if (in_scan) begin
          m_data = rf_mem[m_pending[0]];
          m_addr = m_pending.pop_front();
        end
        if (exp_en) begin
          m_cnt  = m_cnt + 32'd1;
          m_skip = 0;
        end
        if (in_scan) begin
          // scan finishes on its own; control pulses are ignored
        end else if (m_stepping) begin
          m_stepping = 0;
        end else if (m_running) begin
          if (bp) begin
            m_running    = 0;
            m_parked_brk = 1;
          end else if (dbg_if.halt) begin
            m_running = 0;
          end
        end else if (dbg_if.run) begin
          m_running = 1;
          if (m_parked_brk) m_skip = 1;
          m_parked_brk = 0;
        end else if (dbg_if.step) begin
          m_stepping = 1;
          if (m_parked_brk) m_skip = 1;
          m_parked_brk = 0;
        end else if (dbg_if.scan_req) begin
          n = (dbg_if.scan_len == 8'd0) ? 256 : int'(dbg_if.scan_len);
          for (int i = 0; i < n; i++) begin
            m_pending.push_back(dbg_if.scan_start + 8'(i));
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed sequences and random phase
  // -------------------------------------------------------------------------
  initial begin
    int          cnt;
    int          done_k;
    int          valid_cnt;
    bit          found;
    logic [7:0]  exp_scan_addr [4];
    logic [7:0]  got_addr [4];
    logic [7:0]  wrap_a1, wrap_a2, wrap_a256;
    logic [31:0] exp_step_cnt;

    dbg_if.run = 0; dbg_if.halt = 0; dbg_if.step = 0; dbg_if.scan_req = 0;
    dbg_if.brk_en = 0; dbg_if.brk_addr = 32'd0;
    dbg_if.scan_start = 8'd0; dbg_if.scan_len = 8'd0;
    wrap_pc = 32'h20;
    for (int i = 0; i < 256; i++) rf_mem[i] = $urandom;

    // Reset state
    @(negedge clk);
    checkOutput("reset_cpu_en", {31'd0, dbg_if.cpu_en}, 32'd0);
    checkOutput("reset_status", {30'd0, dbg_if.status}, 32'd0);
    checkOutput("reset_m_rf_addr", {24'd0, dbg_if.m_rf_addr}, 32'd0);
    checkOutput("reset_scan_valid", {31'd0, dbg_if.scan_valid}, 32'd0);
    checkOutput("reset_cycle_cnt", dbg_if.cycle_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single step: exactly one enabled cycle, then back to HALT
    $display("[TB] step test");
    applyStimulus(0, 0, 1, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cnt += int'(dbg_if.cpu_en);
    end
    checkOutput("step_en_cycles", 32'(cnt), 32'd1);
    checkOutput("step_status_after", {30'd0, dbg_if.status}, 32'd0);
`ifdef PL_DBG_CYCLE_CNT_EN
    exp_step_cnt = 32'd1;
`else
    exp_step_cnt = 32'd0;
`endif
    checkOutput("step_cycle_cnt", dbg_if.cycle_cnt, exp_step_cnt);
    @(posedge clk); #1;

    // Breakpoint at 0x0C
    $display("[TB] breakpoint test");
    do_reset();
    dbg_if.brk_en   = 1'b1;
    dbg_if.brk_addr = 32'h0000_000C;
    applyStimulus(1, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = (dbg_if.pc == 32'hC);
    end
    checkOutput("bp_reach_pc", {31'd0, found}, 32'd1);
    checkOutput("bp_cpu_en", {31'd0, dbg_if.cpu_en}, 32'd0);
    @(negedge clk);
    checkOutput("bp_status", {30'd0, dbg_if.status}, 32'd2);
    checkOutput("bp_pc_held", dbg_if.pc, 32'hC);
    @(posedge clk); #1;

    // Resume from the breakpoint executes 0x0C once, then breaks again
    $display("[TB] resume test");
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkOutput("resume_pc", dbg_if.pc, 32'hC);
    checkOutput("resume_cpu_en", {31'd0, dbg_if.cpu_en}, 32'd1);
    @(negedge clk);
    checkOutput("resume_pc_next", dbg_if.pc, 32'h10);
    checkOutput("resume_status", {30'd0, dbg_if.status}, 32'd1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = (dbg_if.pc == 32'hC);
    end
    checkOutput("rebreak_reach_pc", {31'd0, found}, 32'd1);
    checkOutput("rebreak_cpu_en", {31'd0, dbg_if.cpu_en}, 32'd0);
    @(negedge clk);
    checkOutput("rebreak_status", {30'd0, dbg_if.status}, 32'd2);
    @(posedge clk); #1;
    dbg_if.brk_en = 1'b0;

    // Scan of 4 words starting at 0x1E from HALT
    $display("[TB] scan test");
    do_reset();
    exp_scan_addr[0] = 8'h1E; exp_scan_addr[1] = 8'h1F;
    exp_scan_addr[2] = 8'h20; exp_scan_addr[3] = 8'h21;
    dbg_if.scan_start = 8'h1E;
    dbg_if.scan_len   = 8'd4;
    applyStimulus(0, 0, 0, 1);
    cnt = 0; valid_cnt = 0; done_k = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (dbg_if.status == 2'd3 && cnt < 4) begin
        got_addr[cnt] = dbg_if.m_rf_addr;
        cnt++;
      end
      if (dbg_if.scan_valid) begin
        if (valid_cnt < 4) checkOutput("scan_word", dbg_if.scan_data, rf_mem[exp_scan_addr[valid_cnt]]);
        valid_cnt++;
      end
      if (dbg_if.scan_done) done_k = k;
    end
    checkOutput("scan_addr_cycles", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("scan_addr", {24'd0, got_addr[i]}, {24'd0, exp_scan_addr[i]});
    checkOutput("scan_valid_count", 32'(valid_cnt), 32'd4);
    checkOutput("scan_done_latency", 32'(done_k), 32'd5);
    checkOutput("scan_status_after", {30'd0, dbg_if.status}, 32'd0);
    @(posedge clk); #1;

    // Wrapping 256-word scan starting at 0xFF
    $display("[TB] wrap scan test");
    dbg_if.scan_start = 8'hFF;
    dbg_if.scan_len   = 8'd0;
    applyStimulus(0, 0, 0, 1);
    valid_cnt = 0; done_k = -1;
    wrap_a1 = 8'd0; wrap_a2 = 8'd0; wrap_a256 = 8'd0;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k == 1)   wrap_a1   = dbg_if.m_rf_addr;
      if (k == 2)   wrap_a2   = dbg_if.m_rf_addr;
      if (k == 256) wrap_a256 = dbg_if.m_rf_addr;
      if (dbg_if.scan_valid) valid_cnt++;
      if (dbg_if.scan_done && done_k < 0) done_k = k;
    end
    checkOutput("wrap_first_addr", {24'd0, wrap_a1}, 32'hFF);
    checkOutput("wrap_second_addr", {24'd0, wrap_a2}, 32'h00);
    checkOutput("wrap_last_addr", {24'd0, wrap_a256}, 32'hFE);
    checkOutput("wrap_valid_count", 32'(valid_cnt), 32'd256);
    checkOutput("wrap_done_latency", 32'(done_k), 32'd257);
    @(posedge clk); #1;

    // Reset in the middle of a scan after two words
    $display("[TB] reset mid-scan test");
    dbg_if.scan_start = 8'h40;
    dbg_if.scan_len   = 8'd8;
    applyStimulus(0, 0, 0, 1);
    valid_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (dbg_if.scan_valid) valid_cnt++;
    end
    checkOutput("midscan_words_before", 32'(valid_cnt), 32'd2);
    #1 rst = 1'b1;
    #1;
    checkOutput("midscan_rst_status", {30'd0, dbg_if.status}, 32'd0);
    checkOutput("midscan_rst_addr", {24'd0, dbg_if.m_rf_addr}, 32'd0);
    checkOutput("midscan_rst_valid", {31'd0, dbg_if.scan_valid}, 32'd0);
    checkOutput("midscan_rst_data", dbg_if.scan_data, 32'd0);
    checkOutput("midscan_rst_cycle_cnt", dbg_if.cycle_cnt, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cnt += int'(dbg_if.scan_done);
    end
    checkOutput("midscan_no_done", 32'(cnt), 32'd0);
    checkOutput("midscan_status_after", {30'd0, dbg_if.status}, 32'd0);
    @(posedge clk); #1;

    // scan_req and step ignored while running
    $display("[TB] ignored inputs test");
    applyStimulus(1, 0, 0, 0);
    dbg_if.scan_start = 8'h10;
    dbg_if.scan_len   = 8'd3;
    applyStimulus(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("run_ignores_scan_status", {30'd0, dbg_if.status}, 32'd1);
    end
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("halt_status", {30'd0, dbg_if.status}, 32'd0);
    @(posedge clk); #1;

    // Random phase
    $display("[TB] random phase");
    for (int c = 0; c < 3000; c++) begin
      dbg_if.run      = ($urandom_range(0, 24) == 0);
      dbg_if.halt     = ($urandom_range(0, 19) == 0);
      dbg_if.step     = ($urandom_range(0, 14) == 0);
      dbg_if.scan_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 19) == 0) dbg_if.brk_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) dbg_if.brk_addr = 32'(4 * $urandom_range(0, 10));
      if ($urandom_range(0, 99) == 0) wrap_pc = 32'(4 * $urandom_range(2, 12));
      dbg_if.scan_start = 8'($urandom);
      dbg_if.scan_len   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
    dbg_if.run = 0; dbg_if.halt = 0; dbg_if.step = 0; dbg_if.scan_req = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
